// File: rtl/alu_ctrl_gen_pkg.sv
// Shared ALU-control definitions: ALU op codes, RV32I opcodes, funct7 values,
// the OUT/SKID occupancy states and the funct3-to-ALU-op mapping helper.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b1111;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;

    // alt selects SUB for funct3 000 and SRA for funct3 101
    function automatic logic [3:0] alu_op(input logic [2:0] funct3, input logic alt);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLT;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_ctrl_gen_if.sv
// Instruction-in / decoded-control-out handshake bundle for alu_ctrl_gen.
// The illegal flag exists only when ALU_DEC_ILLEGAL_EN is defined.
interface alu_ctrl_gen_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_ctrl;
    logic        alu_src_imm;
    logic [31:0] imm_out;
`ifdef ALU_DEC_ILLEGAL_EN
    logic        illegal;
`endif

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, alu_ctrl, alu_src_imm, imm_out
`ifdef ALU_DEC_ILLEGAL_EN
        , input illegal
`endif
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, alu_ctrl, alu_src_imm, imm_out
`ifdef ALU_DEC_ILLEGAL_EN
        , output illegal
`endif
    );
endinterface

// File: rtl/alu_ctrl_gen_decode.sv
// Combinational RV32I decode into ALU op, operand-B select and immediate.
// Illegal-encoding detection is built only with ALU_DEC_ILLEGAL_EN.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output logic [3:0]  alu_ctrl,
    output logic        alu_src_imm,
    output logic [31:0] imm_out
`ifdef ALU_DEC_ILLEGAL_EN
    , output logic      illegal
`endif
);

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic        alt_s;
    logic        is_shift_s;
    logic [31:0] imm_i_s;
    logic [31:0] imm_st_s;
    logic [31:0] imm_b_s;
    logic [31:0] imm_u_s;
    logic [31:0] imm_j_s;

    assign opcode_s   = instr[6:0];
    assign funct3_s   = instr[14:12];
    assign funct7_s   = instr[31:25];
    assign alt_s      = (funct7_s == F7_ALT);
    assign is_shift_s = (funct3_s == 3'b001) || (funct3_s == 3'b101);

    assign imm_i_s  = {{20{instr[31]}}, instr[31:20]};
    assign imm_st_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b_s  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u_s  = {instr[31:12], 12'd0};
    assign imm_j_s  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Field decode; unknown opcodes fall back to ADD with rs2 and a zero immediate
    always_comb begin
        alu_ctrl    = ALU_ADD;
        alu_src_imm = 1'b0;
        imm_out     = 32'd0;
        case (opcode_s)
            OP_R: begin
                alu_ctrl = alu_op(funct3_s, alt_s);
            end
            OP_IMM: begin
                // funct3 000 has no SUB form with an immediate, so alt only matters for 101
                alu_ctrl    = alu_op(funct3_s, alt_s && (funct3_s == 3'b101));
                alu_src_imm = 1'b1;
                if (is_shift_s) begin
                    imm_out = {27'd0, instr[24:20]};
                end else begin
                    imm_out = imm_i_s;
                end
            end
            OP_LOAD, OP_JALR: begin
                alu_src_imm = 1'b1;
                imm_out     = imm_i_s;
            end
            OP_STORE: begin
                alu_src_imm = 1'b1;
                imm_out     = imm_st_s;
            end
            OP_BRANCH: begin
                alu_ctrl = ALU_SUB;
                imm_out  = imm_b_s;
            end
            OP_LUI, OP_AUIPC: begin
                alu_src_imm = 1'b1;
                imm_out     = imm_u_s;
            end
            OP_JAL: begin
                alu_src_imm = 1'b1;
                imm_out     = imm_j_s;
            end
            default: begin
                alu_ctrl    = ALU_ADD;
                alu_src_imm = 1'b0;
                imm_out     = 32'd0;
            end
        endcase
    end

`ifdef ALU_DEC_ILLEGAL_EN
    // Flags unlisted opcodes and funct7/shamt-high patterns outside the base ISA
    always_comb begin
        illegal = 1'b0;
        case (opcode_s)
            OP_R: begin
                if (funct7_s == F7_BASE) begin
                    illegal = 1'b0;
                end else if (alt_s && ((funct3_s == 3'b000) || (funct3_s == 3'b101))) begin
                    illegal = 1'b0;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_IMM: begin
                if (funct3_s == 3'b001) begin
                    illegal = (funct7_s != F7_BASE);
                end else if (funct3_s == 3'b101) begin
                    illegal = !((funct7_s == F7_BASE) || alt_s);
                end else begin
                    illegal = 1'b0;
                end
            end
            OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL: begin
                illegal = 1'b0;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end
`endif

endmodule

// File: rtl/alu_ctrl_gen.sv
// Registered ALU-control generator: decode feeding an OUT register plus a
// one-entry skid buffer. Optional illegal flag: define ALU_DEC_ILLEGAL_EN.
module alu_ctrl_gen
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    alu_ctrl_gen_if.slave bus
);

    logic [3:0]  dec_ctrl_s;
    logic        dec_src_s;
    logic [31:0] dec_imm_s;

    buf_state_t  state_r;
    logic        in_ready_r;
    logic        out_valid_r;
    logic [3:0]  out_ctrl_r;
    logic        out_src_r;
    logic [31:0] out_imm_r;
    logic [3:0]  skid_ctrl_r;
    logic        skid_src_r;
    logic [31:0] skid_imm_r;

    logic        accept_s;
    logic        drain_s;
    logic        load_out_new_s;
    logic        load_out_skid_s;
    logic        load_skid_s;

`ifdef ALU_DEC_ILLEGAL_EN
    logic        dec_ill_s;
    logic        out_ill_r;
    logic        skid_ill_r;
`endif

    alu_ctrl_decode u_decode (
        .instr       (bus.in_instr),
        .alu_ctrl    (dec_ctrl_s),
        .alu_src_imm (dec_src_s),
        .imm_out     (dec_imm_s)
`ifdef ALU_DEC_ILLEGAL_EN
        , .illegal   (dec_ill_s)
`endif
    );

    assign accept_s = bus.in_valid && in_ready_r;
    assign drain_s  = out_valid_r && bus.out_ready;

    // Data-path load strobes; flush suppresses every load
    always_comb begin
        load_out_new_s  = 1'b0;
        load_out_skid_s = 1'b0;
        load_skid_s     = 1'b0;
        if (flush) begin
            load_out_new_s  = 1'b0;
            load_out_skid_s = 1'b0;
            load_skid_s     = 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: load_out_new_s = accept_s;
                ST_ONE: begin
                    load_out_new_s = accept_s && drain_s;
                    load_skid_s    = accept_s && !drain_s;
                end
                ST_FULL:  load_out_skid_s = drain_s;
                default:  load_out_new_s  = 1'b0;
            endcase
        end
    end

    // Occupancy FSM with registered out_valid/in_ready (no comb path from out_ready)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else if (flush) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_r     <= ST_ONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        state_r     <= ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (drain_s && !accept_s) begin
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                    end else if (accept_s && !drain_s) begin
                        state_r     <= ST_FULL;
                        in_ready_r  <= 1'b0;
                    end else begin
                        state_r     <= ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (drain_s) begin
                        state_r     <= ST_ONE;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r     <= ST_FULL;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    // OUT and SKID payload registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_ctrl_r  <= ALU_ADD;
            out_src_r   <= 1'b0;
            out_imm_r   <= 32'd0;
            skid_ctrl_r <= ALU_ADD;
            skid_src_r  <= 1'b0;
            skid_imm_r  <= 32'd0;
        end else begin
            if (load_out_new_s) begin
                out_ctrl_r <= dec_ctrl_s;
                out_src_r  <= dec_src_s;
                out_imm_r  <= dec_imm_s;
            end else if (load_out_skid_s) begin
                out_ctrl_r <= skid_ctrl_r;
                out_src_r  <= skid_src_r;
                out_imm_r  <= skid_imm_r;
            end else begin
                out_ctrl_r <= out_ctrl_r;
            end
            if (load_skid_s) begin
                skid_ctrl_r <= dec_ctrl_s;
                skid_src_r  <= dec_src_s;
                skid_imm_r  <= dec_imm_s;
            end else begin
                skid_ctrl_r <= skid_ctrl_r;
            end
        end
    end

`ifdef ALU_DEC_ILLEGAL_EN
    // Illegal flag travels with its entry through OUT/SKID
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_ill_r  <= 1'b0;
            skid_ill_r <= 1'b0;
        end else begin
            if (load_out_new_s) begin
                out_ill_r <= dec_ill_s;
            end else if (load_out_skid_s) begin
                out_ill_r <= skid_ill_r;
            end else begin
                out_ill_r <= out_ill_r;
            end
            if (load_skid_s) begin
                skid_ill_r <= dec_ill_s;
            end else begin
                skid_ill_r <= skid_ill_r;
            end
        end
    end

    assign bus.illegal = out_ill_r;
`endif

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.alu_ctrl    = out_ctrl_r;
    assign bus.alu_src_imm = out_src_r;
    assign bus.imm_out     = out_imm_r;

endmodule

// File: tb/tb_alu_ctrl_gen.sv
// Self-checking bench for alu_ctrl_gen: directed cases plus randomized traffic
// against an instruction-level reference model and an occupancy queue.
module tb_alu_ctrl_gen;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic        src;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    logic clk;
    logic rst;
    logic flush;
    int   tests;
    int   fails;
    exp_t q[$];

    alu_ctrl_gen_if bus ();

    alu_ctrl_gen dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sign-extend an n-bit field by plain integer arithmetic
    function automatic logic [31:0] sext(input int val, input int nbits);
        int v;
        v = val;
        if (v >= (1 << (nbits - 1))) v = v - (1 << nbits);
        return 32'(v);
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t       e;
        logic [3:0] base [8];
        logic [2:0] f3;
        logic [6:0] f7;
        base = '{4'b0010, 4'b0011, 4'b0111, 4'b0111, 4'b1111, 4'b1000, 4'b0001, 4'b0000};
        f3 = w[14:12];
        f7 = w[31:25];
        e.ctrl = 4'b0010;
        e.src  = 1'b0;
        e.imm  = 32'd0;
        e.ill  = 1'b0;
        case (w[6:0])
            7'h33: begin
                e.ctrl = base[f3];
                if (f7 == 7'h20 && f3 == 3'd0) e.ctrl = 4'b0110;
                if (f7 == 7'h20 && f3 == 3'd5) e.ctrl = 4'b1010;
                e.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            end
            7'h13: begin
                e.ctrl = base[f3];
                if (f7 == 7'h20 && f3 == 3'd5) e.ctrl = 4'b1010;
                e.src = 1'b1;
                if (f3 == 3'd1 || f3 == 3'd5) e.imm = 32'(w[24:20]);
                else e.imm = sext(int'(w[31:20]), 12);
                e.ill = (f3 == 3'd1 && f7 != 7'h00) ||
                        (f3 == 3'd5 && !(f7 == 7'h00 || f7 == 7'h20));
            end
            7'h03, 7'h67: begin
                e.src = 1'b1;
                e.imm = sext(int'(w[31:20]), 12);
            end
            7'h23: begin
                e.src = 1'b1;
                e.imm = sext(int'({w[31:25], w[11:7]}), 12);
            end
            7'h63: begin
                e.ctrl = 4'b0110;
                e.imm  = sext(int'({w[31], w[7], w[30:25], w[11:8]}), 12) * 32'd2;
            end
            7'h37, 7'h17: begin
                e.src = 1'b1;
                e.imm = w & 32'hFFFF_F000;
            end
            7'h6F: begin
                e.src = 1'b1;
                e.imm = sext(int'({w[31], w[19:12], w[20], w[30:21]}), 20) * 32'd2;
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(q.size() > 0));
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(q.size() < 2));
        if (q.size() > 0) begin
            chk({tag, ".alu_ctrl"}, 32'(bus.alu_ctrl), 32'(q[0].ctrl));
            chk({tag, ".alu_src_imm"}, 32'(bus.alu_src_imm), 32'(q[0].src));
            chk({tag, ".imm_out"}, bus.imm_out, q[0].imm);
`ifdef ALU_DEC_ILLEGAL_EN
            chk({tag, ".illegal"}, 32'(bus.illegal), 32'(q[0].ill));
`endif
        end
    endtask

    // One clock: drive, predict handshakes from model occupancy, check after the edge
    task automatic cycle(input string tag, input logic v, input logic [31:0] w,
                         input logic r, input logic f);
        logic acc;
        logic drn;
        bus.in_valid  = v;
        bus.in_instr  = w;
        bus.out_ready = r;
        flush         = f;
        acc = v && (q.size() < 2);
        drn = r && (q.size() > 0);
        @(posedge clk);
        #1;
        if (f) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(ref_decode(w));
        end
        check_outputs(tag);
    endtask

    initial begin
        logic [6:0]  opcs [10];
        logic [31:0] w;
        int          k;
        tests = 0;
        fails = 0;
        opcs = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h00};

        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_instr = 32'd0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst.alu_ctrl", 32'(bus.alu_ctrl), 32'h2);
        chk("rst.alu_src_imm", 32'(bus.alu_src_imm), 32'd0);
        chk("rst.imm_out", bus.imm_out, 32'd0);
`ifdef ALU_DEC_ILLEGAL_EN
        chk("rst.illegal", 32'(bus.illegal), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        cycle("sub", 1'b1, 32'h40B5_0533, 1'b1, 1'b0);
        chk("sub.ctrl", 32'(bus.alu_ctrl), 32'h6);
        chk("sub.src", 32'(bus.alu_src_imm), 32'd0);
        chk("sub.imm", bus.imm_out, 32'd0);
        cycle("addi", 1'b1, 32'hFFF0_0093, 1'b1, 1'b0);
        chk("addi.ctrl", 32'(bus.alu_ctrl), 32'h2);
        chk("addi.imm", bus.imm_out, 32'hFFFF_FFFF);
        cycle("srai", 1'b1, 32'h4033_5293, 1'b1, 1'b0);
        chk("srai.ctrl", 32'(bus.alu_ctrl), 32'hA);
        chk("srai.imm", bus.imm_out, 32'h0000_0003);
        cycle("beq", 1'b1, 32'h0020_8463, 1'b1, 1'b0);
        chk("beq.ctrl", 32'(bus.alu_ctrl), 32'h6);
        chk("beq.src", 32'(bus.alu_src_imm), 32'd0);
        chk("beq.imm", bus.imm_out, 32'h0000_0008);
        cycle("idle", 1'b0, 32'd0, 1'b1, 1'b0);

        // Backpressure: A in OUT, B in SKID, C held until space frees up
        cycle("bp.a", 1'b1, 32'h0050_0113, 1'b0, 1'b0);
        cycle("bp.b", 1'b1, 32'h00A0_0193, 1'b0, 1'b0);
        chk("bp.full_ready", 32'(bus.in_ready), 32'd0);
        cycle("bp.c_held", 1'b1, 32'h0020_81B3, 1'b0, 1'b0);
        chk("bp.hold_imm", bus.imm_out, 32'd5);
        cycle("bp.pop_a", 1'b1, 32'h0020_81B3, 1'b1, 1'b0);
        chk("bp.b_imm", bus.imm_out, 32'd10);
        chk("bp.ready_back", 32'(bus.in_ready), 32'd1);
        cycle("bp.pop_b", 1'b1, 32'h0020_81B3, 1'b1, 1'b0);
        chk("bp.c_src", 32'(bus.alu_src_imm), 32'd0);
        cycle("bp.pop_c", 1'b0, 32'd0, 1'b1, 1'b0);

        // Flush from FULL with a simultaneous input word
        cycle("fl.a", 1'b1, 32'h0050_0113, 1'b0, 1'b0);
        cycle("fl.b", 1'b1, 32'h00A0_0193, 1'b0, 1'b0);
        cycle("fl.flush", 1'b1, 32'h0020_81B3, 1'b1, 1'b1);
        chk("fl.out_valid", 32'(bus.out_valid), 32'd0);
        chk("fl.in_ready", 32'(bus.in_ready), 32'd1);
        cycle("fl.after", 1'b0, 32'd0, 1'b1, 1'b0);

        cycle("zero", 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        chk("zero.ctrl", 32'(bus.alu_ctrl), 32'h2);
`ifdef ALU_DEC_ILLEGAL_EN
        chk("zero.illegal", 32'(bus.illegal), 32'd1);
`endif

        // Asynchronous reset mid-stream
        cycle("mr.a", 1'b1, 32'h0050_0113, 1'b0, 1'b0);
        cycle("mr.b", 1'b1, 32'h00A0_0193, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("mr.out_valid", 32'(bus.out_valid), 32'd0);
        chk("mr.in_ready", 32'(bus.in_ready), 32'd1);
        q.delete();
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 400; i++) begin
            w = $urandom();
            k = int'($urandom_range(0, 10));
            if (k < 10) w[6:0] = opcs[k];
            if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
            cycle("rand", ($urandom_range(0, 3) != 0), w, ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 31) == 0));
        end
        for (int i = 0; i < 3; i++) cycle("drain", 1'b0, 32'd0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_gen.md
# alu_ctrl_gen

Registered ALU-control generator: accepts 32-bit RV32I instruction words over a valid/ready handshake and produces the ALU operation code, operand-B select and sign-extended immediate consumed by the ALU and its operand mux. It is the producer side of the 4-bit ALU control interface. It sits between instruction fetch and the execute datapath, with one output register plus a one-entry skid buffer, so fetch backpressure never forms a combinational ready path.

## Interface
- No parameters; widths are fixed (XLEN 32, ALU control 4).
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous; discards all held entries
- in_valid  in  1  instruction word valid
- in_ready  out  1  registered; high when the skid entry is empty
- in_instr  in  32  instruction word
- out_valid  out  1  decoded entry valid
- out_ready  in  1  downstream accepts
- alu_ctrl  out  4  ALU op: ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 1111, SLT 0111, SLL 0011, SRL 1000, SRA 1010
- alu_src_imm  out  1  1 = operand B from imm_out, 0 = from rs2
- imm_out  out  32  sign-extended immediate (format per opcode)
- illegal  out  1  present only with ALU_DEC_ILLEGAL_EN

## Operation
- Decode is a pure function of in_instr; the result is registered with the entry.
- R-type 0110011: funct3 000 → ADD, or SUB when funct7 = 0100000. 111 AND, 110 OR, 100 XOR, 001 SLL. 101 → SRL, or SRA when funct7 = 0100000. 010 and 011 both → SLT. alu_src_imm 0. imm_out 0.
- I-ALU 0010011: same mapping, except funct3 000 is always ADD. alu_src_imm 1. imm_out is the I-immediate; for shifts it is zero-extended shamt[4:0].
- Load 0000011, JALR 1100111: ADD, alu_src_imm 1, I-immediate.
- Store 0100011: ADD, alu_src_imm 1, S-immediate.
- Branch 1100011: SUB, alu_src_imm 0, B-immediate (bit 0 = 0).
- LUI 0110111, AUIPC 0010111: ADD, alu_src_imm 1, U-immediate (low 12 bits zero).
- JAL 1101111: ADD, alu_src_imm 1, J-immediate.
- Any other opcode: ADD, alu_src_imm 0, imm_out 0. This is the illegal case.
- Storage consists of the output register (OUT) and the skid register (SKID). States are EMPTY (neither valid), ONE (OUT valid), and FULL (OUT and SKID valid).
  - EMPTY + accept → ONE.
  - ONE + accept + out_ready → ONE, with new data.
  - ONE + out_ready, no accept → EMPTY.
  - ONE + accept, no out_ready → FULL.
  - FULL + out_ready → ONE, with OUT loaded from SKID.
- in_ready = (SKID empty). It is registered, so it is never combinationally derived from out_ready.
- A handshake occurs on in_valid && in_ready, or on out_valid && out_ready.
- Order is strictly preserved.

## Timing
- Latency: 1 cycle, from the accept edge to out_valid.
- Throughput: 1 instruction per cycle while out_ready stays high.
- Reset: out_valid 0, in_ready 1, alu_ctrl 0010, alu_src_imm 0, imm_out 0, illegal 0, SKID invalid.
- Reset mid-operation drops all entries immediately (asynchronous).
- Output data holds stable while out_valid && !out_ready.
- flush takes priority over a simultaneous accept or out_ready:
  - both entries are invalidated next cycle;
  - the same-cycle input is dropped;
  - in_ready is 1 the next cycle.
- In FULL, in_ready is 0. A FULL → ONE transition raises in_ready the following cycle.

## Configuration
- ALU_DEC_ILLEGAL_EN defined: the illegal output exists and is registered with the entry.
  - It is 1 for unlisted opcodes, R-type funct7 outside {0000000, 0100000}, and 0100000 with funct3 outside {000, 101}.
  - It is also 1 for I-type shifts with an illegal imm[11:5].
  - Decode fields still follow the default rules.
- Undefined: no illegal port; unsupported encodings silently decode per the default rules.

## Structure
- A shared package alu_pkg holds:
  - the 4-bit ALU op localparams (ALU_ADD … ALU_XOR);
  - the 7-bit opcode constants;
  - the funct7 constants.
- The sub-module alu_ctrl_decode is combinational: instr in, {alu_ctrl, alu_src_imm, imm_out, illegal} out.
- alu_ctrl_gen instantiates alu_ctrl_decode and owns the OUT/SKID registers and the handshake.

## Test plan
- 0x40B50533 (sub x10,x10,x11), out_ready = 1 → next cycle: out_valid 1, alu_ctrl 0110, alu_src_imm 0, imm_out 0.
- 0xFFF00093 (addi x1,x0,-1) → alu_ctrl 0010, alu_src_imm 1, imm_out 0xFFFFFFFF.
- 0x40335293 (srai x5,x6,3) → alu_ctrl 1010, imm_out 0x00000003. Then 0x00208463 (beq x1,x2,+8) → alu_ctrl 0110, alu_src_imm 0, imm_out 0x00000008.
- out_ready = 0, push A, B, C back-to-back:
  - A is in OUT, B in SKID;
  - in_ready falls after B, and C is held;
  - raising out_ready yields A, B, C in order, one per cycle.
- FULL state, assert flush together with in_valid → next cycle out_valid 0, in_ready 1; the flushed and same-cycle words never appear.
- 0x00000000 with ALU_DEC_ILLEGAL_EN → illegal 1, alu_ctrl 0010. Assert rst mid-stream → out_valid 0 immediately, in_ready 1.
